// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types, segment patterns and BCD helpers for the
//               mm:ss stopwatch / countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Active-high segment patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  // Shown for any digit outside 0-9: middle bar only
  localparam logic [6:0] SEG_G = 7'h01;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

  // True when every nibble of {min2,min1,sec2,sec1} is within its mm:ss range
  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[3:0]   <= BCD_MAX_ONES) && (v[7:4]   <= BCD_MAX_TENS) &&
           (v[11:8]  <= BCD_MAX_ONES) && (v[15:12] <= BCD_MAX_TENS);
  endfunction

  // One-second step of the mm:ss value; carry (up) or borrow (down) ripples
  // from sec1 towards min2, wrapping 59:59 <-> 00:00 at the ends.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic down);
    logic [15:0] r;
    logic        carry;
    logic [3:0]  d;
    logic [3:0]  mx;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d  = v[i*4 +: 4];
      mx = ((i % 2) == 0) ? BCD_MAX_ONES : BCD_MAX_TENS;
      if (carry) begin
        if (down) begin
          if (d == 4'd0) begin
            d = mx;
          end else begin
            d     = d - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == mx) begin
            d = 4'd0;
          end else begin
            d     = d + 4'd1;
            carry = 1'b0;
          end
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_7seg_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : BCD digit to seven-segment pattern with selectable polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import stopwatch_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_hi_w;

  // Active-high lookup, then polarity fix-up for the board pins
  always_comb begin
    seg_hi_w = SEG_G;
    case (digit_i)
      4'd0:    seg_hi_w = SEG_0;
      4'd1:    seg_hi_w = SEG_1;
      4'd2:    seg_hi_w = SEG_2;
      4'd3:    seg_hi_w = SEG_3;
      4'd4:    seg_hi_w = SEG_4;
      4'd5:    seg_hi_w = SEG_5;
      4'd6:    seg_hi_w = SEG_6;
      4'd7:    seg_hi_w = SEG_7;
      4'd8:    seg_hi_w = SEG_8;
      4'd9:    seg_hi_w = SEG_9;
      default: seg_hi_w = SEG_G;
    endcase
  end

  assign seg_o = (SEG_ACTIVE_LOW != 0) ? ~seg_hi_w : seg_hi_w;

endmodule
`default_nettype wire

// File: rtl/stopwatch_7seg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_7seg
// Description : mm:ss stopwatch / countdown timer with four seven-segment
//               digit outputs, start/pause/clear/load commands and done flag.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_7seg
  import stopwatch_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 50_000_000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        count_down,
  output logic        tick,
  output logic        running,
  output logic        done,
  output logic        load_err,
  output logic [15:0] bcd,
  output logic [6:0]  sec1,
  output logic [6:0]  sec2,
  output logic [6:0]  min1,
  output logic [6:0]  min2
);

  localparam int             PW        = $clog2(CYCLES_PER_SEC);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CYCLES_PER_SEC - 1);

  state_t        state_q,    state_d;
  logic [PW-1:0] presc_q,    presc_d;
  logic [15:0]   digits_q,   digits_d;
  logic          tick_q,     tick_d;
  logic          load_err_q, load_err_d;

  logic          start_cmd_w;
  logic          pause_cmd_w;
  logic [15:0]   step_w;

  // start and pause together cancel each other
  assign start_cmd_w = start & ~pause;
  assign pause_cmd_w = pause & ~start;
  assign step_w      = bcd_step(digits_q, count_down);

  // State, prescaler and digit registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      digits_q   <= 16'h0000;
      tick_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      digits_q   <= digits_d;
      tick_q     <= tick_d;
      load_err_q <= load_err_d;
    end
  end

  // Command decode (clear > load > start/pause), prescaler and BCD update
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    digits_d   = digits_q;
    tick_d     = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      presc_d  = '0;
      digits_d = 16'h0000;
    end else if (load) begin
      if (bcd_valid(load_val)) begin
        state_d  = IDLE;
        presc_d  = '0;
        digits_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (start_cmd_w) begin
            // A countdown from 00:00 has nothing to count
            state_d = (count_down && (digits_q == 16'h0000)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (pause_cmd_w) begin
            state_d = PAUSE;
          end else if (presc_q == PRESC_MAX) begin
            presc_d  = '0;
            digits_d = step_w;
            tick_d   = 1'b1;
            if (count_down && (step_w == 16'h0000)) begin
              state_d = DONE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign tick     = tick_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign load_err = load_err_q;
  assign bcd      = digits_q;

  logic [6:0] seg_w [4];

  generate
    for (genvar g = 0; g < 4; g++) begin : g_seg
      seg7_decode #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
      ) u_dec (
        .digit_i(digits_q[g*4 +: 4]),
        .seg_o  (seg_w[g])
      );
    end
  endgenerate

  assign sec1 = seg_w[0];
  assign sec2 = seg_w[1];
  assign min1 = seg_w[2];
  assign min2 = seg_w[3];

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_7seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_7seg
// Description : Directed, table-driven bench for stopwatch_7seg at
//               CYCLES_PER_SEC=4, SEG_ACTIVE_LOW=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_7seg;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, pause, clear, load, count_down;
  logic [15:0] load_val;
  logic        tick, running, done, load_err;
  logic [15:0] bcd;
  logic [6:0]  sec1, sec2, min1, min2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stopwatch_7seg #(
    .CYCLES_PER_SEC(4),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .count_down(count_down),
    .tick      (tick),
    .running   (running),
    .done      (done),
    .load_err  (load_err),
    .bcd       (bcd),
    .sec1      (sec1),
    .sec2      (sec2),
    .min1      (min1),
    .min2      (min2)
  );

  typedef struct {
    logic [15:0] val;
    logic [15:0] exp_bcd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  // Independent active-low segment reference
  function automatic logic [6:0] seg_exp(input logic [3:0] d);
    logic [6:0] hi;
    case (d)
      4'd0: hi = 7'h7E;  4'd1: hi = 7'h30;  4'd2: hi = 7'h6D;
      4'd3: hi = 7'h79;  4'd4: hi = 7'h33;  4'd5: hi = 7'h5B;
      4'd6: hi = 7'h5F;  4'd7: hi = 7'h70;  4'd8: hi = 7'h7F;
      4'd9: hi = 7'h7B;  default: hi = 7'h01;
    endcase
    return ~hi;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_segs(input string name, input logic [15:0] v);
    chk({name, " sec1"}, 32'(sec1), 32'(seg_exp(v[3:0])));
    chk({name, " sec2"}, 32'(sec2), 32'(seg_exp(v[7:4])));
    chk({name, " min1"}, 32'(min1), 32'(seg_exp(v[11:8])));
    chk({name, " min2"}, 32'(min2), 32'(seg_exp(v[15:12])));
  endtask

  // Advance one clock; outputs settle 1 time unit after the edge
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; cyc(); pause = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v; cyc(); load = 1'b0;
  endtask

  initial begin
    int bad;
    int nticks;

    vecs[0] = '{val: 16'h1234, exp_bcd: 16'h1234, exp_err: 1'b0};
    vecs[1] = '{val: 16'h6000, exp_bcd: 16'h1234, exp_err: 1'b1};
    vecs[2] = '{val: 16'h0A00, exp_bcd: 16'h1234, exp_err: 1'b1};
    vecs[3] = '{val: 16'h5959, exp_bcd: 16'h5959, exp_err: 1'b0};
    vecs[4] = '{val: 16'h00F0, exp_bcd: 16'h5959, exp_err: 1'b1};
    vecs[5] = '{val: 16'h000A, exp_bcd: 16'h5959, exp_err: 1'b1};
    vecs[6] = '{val: 16'h0907, exp_bcd: 16'h0907, exp_err: 1'b0};
    vecs[7] = '{val: 16'h0860, exp_bcd: 16'h0907, exp_err: 1'b1};

    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0;
    load_val = 16'h0000; count_down = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc();

    // Reset state
    chk("reset bcd", 32'(bcd), 32'h0000);
    chk("reset running", 32'(running), 0);
    chk("reset done", 32'(done), 0);
    chk("reset load_err", 32'(load_err), 0);
    chk("reset tick", 32'(tick), 0);
    chk_segs("reset seg", 16'h0000);

    // Idle: no ticks
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tick !== 1'b0) bad++;
    end
    chk("idle tick count", 32'(bad), 0);
    chk("idle bcd", 32'(bcd), 32'h0000);

    // Count up one minute: tick on every 4th edge after start
    pulse_start();
    chk("run running", 32'(running), 1);
    bad = 0; nticks = 0;
    for (int i = 0; i < 240; i++) begin
      cyc();
      if (tick !== ((i % 4) == 3)) bad++;
      if (tick === 1'b1) nticks++;
    end
    chk("up tick pattern errors", 32'(bad), 0);
    chk("up tick total", 32'(nticks), 60);
    chk("up bcd", 32'(bcd), 32'h0100);
    chk("up min1 seg", 32'(min1), 32'h4F);
    chk_segs("up seg", 16'h0100);

    // 59:59 wraps to 00:00 and keeps running
    do_load(16'h5959);
    chk("load running", 32'(running), 0);
    pulse_start();
    cyc(3);
    chk("wrap pre tick", 32'(tick), 0);
    cyc();
    chk("wrap tick", 32'(tick), 1);
    chk("wrap bcd", 32'(bcd), 32'h0000);
    chk("wrap running", 32'(running), 1);

    // Countdown from 00:02 to DONE
    do_load(16'h0002);
    count_down = 1'b1;
    pulse_start();
    cyc(4);
    chk("down tick1", 32'(tick), 1);
    chk("down bcd1", 32'(bcd), 32'h0001);
    chk("down running1", 32'(running), 1);
    cyc(4);
    chk("down tick2", 32'(tick), 1);
    chk("down bcd2", 32'(bcd), 32'h0000);
    chk("down done", 32'(done), 1);
    chk("down running2", 32'(running), 0);
    pulse_start();
    cyc();
    chk("done after start", 32'(done), 1);
    chk("done bcd held", 32'(bcd), 32'h0000);

    // Start into countdown from 00:00 goes straight to DONE without a tick
    pulse_clear();
    pulse_start();
    chk("zero start done", 32'(done), 1);
    chk("zero start tick", 32'(tick), 0);
    count_down = 1'b0;

    // Pause keeps the sub-second phase
    pulse_clear();
    pulse_start();
    cyc(2);
    pulse_pause();
    chk("pause running", 32'(running), 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (tick !== 1'b0) bad++;
    end
    chk("pause tick count", 32'(bad), 0);
    chk("pause bcd", 32'(bcd), 32'h0000);
    pulse_start();
    cyc();
    chk("resume tick+1", 32'(tick), 0);
    cyc();
    chk("resume tick+2", 32'(tick), 1);
    chk("resume bcd", 32'(bcd), 32'h0001);

    // start and pause together are ignored
    start = 1'b1; pause = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
    chk("start+pause running", 32'(running), 1);

    // Load validation table
    pulse_clear();
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].val);
      chk($sformatf("load[%0d] bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
      chk($sformatf("load[%0d] err", i), 32'(load_err), 32'(vecs[i].exp_err));
      chk_segs($sformatf("load[%0d] seg", i), vecs[i].exp_bcd);
      cyc();
      chk($sformatf("load[%0d] err drop", i), 32'(load_err), 0);
    end

    // clear wins over a simultaneous load
    clear = 1'b1; load = 1'b1; load_val = 16'h1234;
    cyc();
    clear = 1'b0; load = 1'b0;
    chk("clear+load bcd", 32'(bcd), 32'h0000);

    // Asynchronous reset mid-run
    do_load(16'h0345);
    pulse_start();
    cyc(5);
    chk("pre-rst bcd", 32'(bcd), 32'h0346);
    rst = 1'b1;
    #1;
    chk("async rst bcd", 32'(bcd), 32'h0000);
    chk("async rst running", 32'(running), 0);
    chk("async rst done", 32'(done), 0);
    chk("async rst tick", 32'(tick), 0);
    chk("async rst load_err", 32'(load_err), 0);
    chk_segs("async rst seg", 16'h0000);
    cyc();
    rst = 1'b0;
    cyc();
    chk("post rst running", 32'(running), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_7seg.md
# stopwatch_7seg

Parametrised mm:ss stopwatch/countdown timer with four BCD digits and four seven-segment outputs. It is the next generation of the free-running seconds counter. Over that counter it adds:
- a configurable clock rate and segment polarity;
- up/down count mode and a preset load;
- single-cycle start/pause/clear commands with a done flag.

It sits between the board push-button conditioning and the display pins.

## Interface
- CYCLES_PER_SEC, 50_000_000: clk cycles per counted second; must be ≥2.
- SEG_ACTIVE_LOW, 1: 1 = segment lit by 0, 0 = lit by 1.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset. Asynchronous, active-high; all state returns to reset values immediately.
- start  in  1  one-cycle command: begin/resume counting.
- pause  in  1  one-cycle command: hold count and prescaler.
- clear  in  1  one-cycle command: digits and prescaler to 0, state IDLE.
- load  in  1  one-cycle command: digits ← load_val, prescaler ← 0, state IDLE.
- load_val  in  16  BCD {min2,min1,sec2,sec1}; min2/sec2 range 0–5, min1/sec1 range 0–9.
- count_down  in  1  0 = count up, 1 = count down. Sampled at every second boundary.
- tick  out  1  one-cycle pulse on every digit update.
- running  out  1  high while in RUN.
- done  out  1  level, high in DONE.
- load_err  out  1  one-cycle pulse when load_val is not valid BCD mm:ss.
- bcd  out  16  current digits {min2,min1,sec2,sec1}.
- sec1, sec2, min1, min2  out  7 each  segments {a,b,c,d,e,f,g}, a = MSB.

## Operation
- States:
  - IDLE: no counting; prescaler held.
  - RUN: prescaler counts; digits update.
  - PAUSE: prescaler and digits held.
  - DONE: countdown reached 00:00; everything held.
- Command priority per cycle: clear > load > start/pause. start and pause asserted together are ignored.
- Transitions:
  - IDLE –start→ RUN.
  - RUN –pause→ PAUSE.
  - PAUSE –start→ RUN.
  - RUN –countdown reaches 00:00→ DONE.
  - any –clear/load→ IDLE.
  - start in DONE is ignored.
- Start into a countdown from 00:00: if start is issued in IDLE or PAUSE with count_down=1 and digits 00:00, go directly to DONE. No tick is generated.
- Prescaler:
  - Width is $clog2(CYCLES_PER_SEC); it counts 0..CYCLES_PER_SEC-1 in RUN only.
  - On the terminal value it wraps to 0 and a second boundary occurs.
  - Pause keeps the sub-second phase.
- Up count at a boundary:
  - sec1 9→0 carries to sec2; sec2 5→0 carries to min1; min1 9→0 carries to min2.
  - 59:59 wraps to 00:00 and stays in RUN.
- Down count at a boundary:
  - Mirror borrow chain: sec1 0→9, sec2 0→5, min1 0→9, min2 0→5.
  - The boundary producing 00:00 enters DONE in the same update.
- Load validation:
  - An invalid load_val (any nibble out of its range) leaves digits and state unchanged and pulses load_err.
  - An invalid load still lets a simultaneous clear win, since clear has priority.
- Segment encoding, active-high, for digits 0–9: 7E,30,6D,79,33,5B,5F,70,7F,7B.
  - Output is the bitwise inverse when SEG_ACTIVE_LOW=1, so digit 0 = 7'b0000001.

## Timing
- Reset values:
  - state IDLE; digits 0000; prescaler 0.
  - tick, running, done, load_err = 0.
  - bcd = 16'h0000.
  - All seg outputs show 0: 7'b0000001 active-low, 7'b1111110 active-high.
- Command latency:
  - A command sampled at edge N changes state and registers at edge N.
  - running and done are valid after edge N (registered outputs).
- Counting latency:
  - After start, the first tick occurs CYCLES_PER_SEC cycles later when starting from prescaler 0.
  - Digits, bcd and tick all update on the same edge.
- seg outputs are a combinational decode of the digit registers: zero extra latency relative to bcd.
- load_err is registered: asserted for the single cycle after the offending load edge.
- count_down changing mid-second takes effect at the next boundary only.

## Structure
- Package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE};
  - 7-bit active-high segment constants SEG_0..SEG_9;
  - BCD digit max constants (9, 5).
- Sub-module seg7_decode (4-bit digit in, parameter SEG_ACTIVE_LOW, 7-bit out); instantiated four times.
  - Out-of-range input shows segment g only.
- Top level holds the FSM, prescaler, BCD chain and load validation.

## Test plan
All scenarios use CYCLES_PER_SEC=4 and SEG_ACTIVE_LOW=1.
- Reset, then 20 idle cycles → bcd=0000, all seg=7'b0000001, tick never asserted.
- start, run 4×60 cycles up → tick every 4th cycle; bcd=0100; min1 seg=7'b1001111.
- load 16'h5959, start, 1 second up → bcd wraps to 0000, state stays RUN.
- load 16'h0002, count_down=1, start → ticks at +4 and +8 cycles, bcd=0000, done=1, running=0; a further start leaves done=1.
- start, pause after 2 cycles, wait 50, start → next tick exactly 2 cycles after resume.
- load 16'h6000 → load_err pulses one cycle, bcd unchanged. clear+load together → bcd=0000. rst asserted mid-RUN → all outputs at reset values before the next clk edge.
